// File: rtl/vtc_timing.sv
// Video timing controller: free-running pixel/line counters with registered sync and active flags.
// Optional VTC_FRAME_PULSE_EN adds registered o_line_start / o_frame_start pulses.
module vtc_timing #(
  parameter int COUNTER_WIDTH = 10,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit SYNC_POL      = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_hsync,
  output logic                     o_vsync,
  output logic                     o_active,
`ifdef VTC_FRAME_PULSE_EN
  output logic                     o_line_start,
  output logic                     o_frame_start,
`endif
  output logic [COUNTER_WIDTH-1:0] o_counterX,
  output logic [COUNTER_WIDTH-1:0] o_counterY
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COUNTER_WIDTH-1:0] H_LAST = COUNTER_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] V_LAST = COUNTER_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] H_ACT  = COUNTER_WIDTH'(H_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] V_ACT  = COUNTER_WIDTH'(V_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] HS_BEG = COUNTER_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COUNTER_WIDTH-1:0] HS_END = COUNTER_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNTER_WIDTH-1:0] VS_BEG = COUNTER_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COUNTER_WIDTH-1:0] VS_END = COUNTER_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [COUNTER_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                     hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;

  // Flags are decoded from the next counter values so they land on the same edge as the counters.
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
    active_d = (x_d < H_ACT) && (y_d < V_ACT);
    hsync_d  = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q      <= H_LAST;
      y_q      <= V_LAST;
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign o_counterX = x_q;
  assign o_counterY = y_q;
  assign o_active   = active_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;

`ifdef VTC_FRAME_PULSE_EN
  logic line_start_q, frame_start_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= (x_d == '0);
      frame_start_q <= (x_d == '0) && (y_d == '0);
    end
  end

  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vtc_timing.sv
// Scoreboard bench for vtc_timing using a shrunken timing so whole frames fit in a short run.
module tb_vtc_timing;
  localparam int CW  = 6;
  localparam int HA  = 20, HFP = 4, HS = 6, HBP = 5;
  localparam int VA  = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;   // 35
  localparam int VT  = VA + VFP + VS + VBP;   // 19

  logic          clk, rst;
  logic          hsync, vsync, active;
  logic [CW-1:0] cx, cy;
`ifdef VTC_FRAME_PULSE_EN
  logic          line_start, frame_start;
`endif

  vtc_timing #(
    .COUNTER_WIDTH(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .o_hsync(hsync), .o_vsync(vsync), .o_active(active),
`ifdef VTC_FRAME_PULSE_EN
    .o_line_start(line_start), .o_frame_start(frame_start),
`endif
    .o_counterX(cx), .o_counterY(cy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int x; int y; bit act; bit hs; bit vs; bit ls; bit fs;} exp_t;
  exp_t sb[$];

  int tot = 0, bad = 0;
  int mx, my;
  int cyc = 0, last00 = -1;
  int act_cnt, hs_low, vs_low, corner, ls_cnt, fs_cnt;

  task automatic chk(input string tag, input int obs, input int exp_v);
    tot++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_x"},  int'(cx), HT - 1);
    chk({pfx, "_y"},  int'(cy), VT - 1);
    chk({pfx, "_act"}, int'(active), 0);
    chk({pfx, "_hs"}, int'(hsync), 1);
    chk({pfx, "_vs"}, int'(vsync), 1);
`ifdef VTC_FRAME_PULSE_EN
    chk({pfx, "_ls"}, int'(line_start), 0);
    chk({pfx, "_fs"}, int'(frame_start), 0);
`endif
  endtask

  task automatic clr_stats();
    act_cnt = 0; hs_low = 0; vs_low = 0; corner = 0; ls_cnt = 0; fs_cnt = 0;
  endtask

  // Advance the model one pixel, queue the expectation, clock the DUT and compare.
  task automatic step();
    exp_t e;
    if (mx == HT - 1) begin
      mx = 0;
      my = (my == VT - 1) ? 0 : my + 1;
    end else mx++;
    e.x   = mx;
    e.y   = my;
    e.act = (mx < HA) && (my < VA);
    e.hs  = !((mx >= HA + HFP) && (mx < HA + HFP + HS));
    e.vs  = !((my >= VA + VFP) && (my < VA + VFP + VS));
    e.ls  = (mx == 0);
    e.fs  = (mx == 0) && (my == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("x", int'(cx), e.x);
    chk("y", int'(cy), e.y);
    chk("act", int'(active), int'(e.act));
    chk("hs", int'(hsync), int'(e.hs));
    chk("vs", int'(vsync), int'(e.vs));
`ifdef VTC_FRAME_PULSE_EN
    chk("ls", int'(line_start), int'(e.ls));
    chk("fs", int'(frame_start), int'(e.fs));
    if (line_start)  ls_cnt++;
    if (frame_start) fs_cnt++;
`endif
    if (active) act_cnt++;
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if (int'(cx) == HA && int'(cy) == VA) corner++;
    if (cx == '0 && cy == '0) begin
      if (last00 >= 0) chk("frame_period", cyc - last00, HT * VT);
      last00 = cyc;
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    mx = HT - 1; my = VT - 1;
    clr_stats();
    repeat (3) @(negedge clk);
    chk_reset("mid_rst");
    repeat (2) @(negedge clk);
    chk_reset("at_rel");
    rst = 1'b0;

    // Frame 1: from (0,0) through (HT-1,VT-1).
    repeat (HT * VT) step();
    chk("f1_active_cnt", act_cnt, HA * VA);
    chk("f1_hsync_low", hs_low, HS * VT);
    chk("f1_vsync_low", vs_low, VS * HT);
    chk("f1_corner_hits", corner, 1);

    // Frame 2 plus wrap back to (0,0); pulse counts span two full frames.
    repeat (HT * VT) step();
    chk("f2_corner_hits", corner, 2);
`ifdef VTC_FRAME_PULSE_EN
    chk("ls_cnt_2f", ls_cnt, 2 * VT);
    chk("fs_cnt_2f", fs_cnt, 2);
`endif
    step();
    chk("wrap_x", int'(cx), 0);
    chk("wrap_y", int'(cy), 0);

    // Asynchronous reset mid-frame at (10,5).
    while (!(mx == 10 && my == 5)) step();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    @(posedge clk); #1 chk_reset("held_rst");
    @(negedge clk);
    rst = 1'b0;
    mx = HT - 1; my = VT - 1;
    last00 = -1;
    step();
    chk("restart_x", int'(cx), 0);
    chk("restart_y", int'(cy), 0);
    repeat (3 * HT) step();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
